// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: instruction opcodes and the memory-stage FSM encoding.
package mem_stage_pkg;

  // Opcodes shared with the pipeline registers
  localparam logic [5:0] NOP   = 6'h00;
  localparam logic [5:0] IROP  = 6'h01;
  localparam logic [5:0] IJ    = 6'h02;
  localparam logic [5:0] IADDI = 6'h08;
  localparam logic [5:0] IANDI = 6'h0C;
  localparam logic [5:0] IORI  = 6'h0D;
  localparam logic [5:0] ILW   = 6'h23;
  localparam logic [5:0] ISW   = 6'h2B;

  // Data-memory access FSM
  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } memState_e;

  // True for opcodes that touch data memory
  function automatic logic isMemOp(input logic [5:0] op);
    return (op == ILW) || (op == ISW);
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Data memory: 2^ADDR_W x 32 words, synchronous write, asynchronous read. Contents are not reset.
module data_mem #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Word write on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data-memory access with configurable latency, stall request, and the W register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  M_op,
  input  logic [31:0] M_valE,
  input  logic [31:0] M_valA,
  input  logic [4:0]  M_dstE,
  input  logic [4:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic        m_busy,
  output logic [5:0]  W_op,
  output logic [31:0] W_valE,
  output logic [31:0] W_valM,
  output logic [4:0]  W_dstE,
  output logic [4:0]  W_dstM,
  output logic        W_err
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'((MEM_LAT == 0) ? 0 : MEM_LAT - 1);

  memState_e        state;
  logic [CntW-1:0]  cnt;
  logic             memOp;
  logic             misal;
  logic             doAccess;
  logic             complete;
  logic             memWe;
  logic [ADDR_W-1:0] wordIdx;
  logic [31:0]      rdData;
  logic [31:0]      loadVal;

  assign memOp    = isMemOp(M_op);
  assign misal    = memOp && (M_valE[1:0] != 2'b00);
  assign doAccess = memOp && !misal;
  // Upper address bits are dropped so addresses wrap modulo the memory size
  assign wordIdx  = M_valE[ADDR_W+1:2];

  // Stall request: waiting to enter ACCESS, or still counting down inside it
  always_comb begin
    m_busy = 1'b0;
    if (state == StAccess) begin
      m_busy = (cnt != '0);
    end else begin
      m_busy = doAccess && (MEM_LAT != 0);
    end
  end

  // The access completes in whichever cycle the stage is not asking for a stall
  assign complete = !m_busy;
  assign memWe    = complete && !W_stall && !rst && doAccess && (M_op == ISW);
  assign loadVal  = (doAccess && (M_op == ILW)) ? rdData : 32'h0;

  data_mem #(
    .ADDR_W(ADDR_W)
  ) u_data_mem (
    .clk  (clk),
    .we   (memWe),
    .addr (wordIdx),
    .wdata(M_valA),
    .rdata(rdData)
  );

  // Access FSM; W_stall freezes both state and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      cnt   <= '0;
    end else if (!W_stall) begin
      unique case (state)
        StIdle: begin
          if (m_busy) begin
            state <= StAccess;
            cnt   <= CntInit;
          end
        end
        StAccess: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= StIdle;
          end
        end
      endcase
    end
  end

  // W pipeline register: stall holds, bubble or busy inserts a NOP, otherwise capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      W_op   <= NOP;
      W_valE <= '0;
      W_valM <= '0;
      W_dstE <= '0;
      W_dstM <= '0;
      W_err  <= 1'b0;
    end else if (W_stall) begin
      W_op   <= W_op;
      W_valE <= W_valE;
      W_valM <= W_valM;
      W_dstE <= W_dstE;
      W_dstM <= W_dstM;
      W_err  <= W_err;
    end else if (W_bubble || m_busy) begin
      W_op   <= NOP;
      W_valE <= '0;
      W_valM <= '0;
      W_dstE <= '0;
      W_dstM <= '0;
      W_err  <= 1'b0;
    end else begin
      W_op   <= M_op;
      W_valE <= M_valE;
      W_valM <= loadVal;
      W_dstE <= M_dstE;
      W_dstM <= M_dstM;
      W_err  <= misal;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: instance 0 has MEM_LAT=2/ADDR_W=10, instance 1 has MEM_LAT=0/ADDR_W=4.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] valE;
    logic [31:0] valM;
    logic [4:0]  dstE;
    logic [4:0]  dstM;
    logic        err;
  } wRec_t;

  typedef struct {
    int          d;
    logic [5:0]  op;
    logic [31:0] valE;
    logic [31:0] valA;
    logic [4:0]  dstE;
    logic [4:0]  dstM;
    logic        bub;
    logic [31:0] expValM;
    logic        expErr;
    logic        expBusy;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [5:0]  mOp    [2];
  logic [31:0] mValE  [2];
  logic [31:0] mValA  [2];
  logic [4:0]  mDstE  [2];
  logic [4:0]  mDstM  [2];
  logic        wStall [2];
  logic        wBub   [2];
  logic        busy   [2];
  logic [5:0]  wOp    [2];
  logic [31:0] wValE  [2];
  logic [31:0] wValM  [2];
  logic [4:0]  wDstE  [2];
  logic [4:0]  wDstM  [2];
  logic        wErr   [2];

  int unsigned lat [2];
  int nChecks;
  int nErrors;
  wRec_t sbq[$];
  vec_t  vecs[$];

  mem_stage #(
    .ADDR_W (10),
    .MEM_LAT(2)
  ) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .M_op    (mOp[0]),
    .M_valE  (mValE[0]),
    .M_valA  (mValA[0]),
    .M_dstE  (mDstE[0]),
    .M_dstM  (mDstM[0]),
    .W_stall (wStall[0]),
    .W_bubble(wBub[0]),
    .m_busy  (busy[0]),
    .W_op    (wOp[0]),
    .W_valE  (wValE[0]),
    .W_valM  (wValM[0]),
    .W_dstE  (wDstE[0]),
    .W_dstM  (wDstM[0]),
    .W_err   (wErr[0])
  );

  mem_stage #(
    .ADDR_W (4),
    .MEM_LAT(0)
  ) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .M_op    (mOp[1]),
    .M_valE  (mValE[1]),
    .M_valA  (mValA[1]),
    .M_dstE  (mDstE[1]),
    .M_dstM  (mDstM[1]),
    .W_stall (wStall[1]),
    .W_bubble(wBub[1]),
    .m_busy  (busy[1]),
    .W_op    (wOp[1]),
    .W_valE  (wValE[1]),
    .W_valM  (wValM[1]),
    .W_dstE  (wDstE[1]),
    .W_dstM  (wDstM[1]),
    .W_err   (wErr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkW(input int d, input string tag, input wRec_t e);
    check({tag, ".W_op"},   32'(wOp[d]),   32'(e.op));
    check({tag, ".W_valE"}, wValE[d],      e.valE);
    check({tag, ".W_valM"}, wValM[d],      e.valM);
    check({tag, ".W_dstE"}, 32'(wDstE[d]), 32'(e.dstE));
    check({tag, ".W_dstM"}, 32'(wDstM[d]), 32'(e.dstM));
    check({tag, ".W_err"},  32'(wErr[d]),  32'(e.err));
  endtask

  task automatic driveNop(input int d);
    mOp[d]   = NOP;
    mValE[d] = '0;
    mValA[d] = '0;
    mDstE[d] = '0;
    mDstM[d] = '0;
  endtask

  function automatic vec_t mk(input int d, input logic [5:0] op, input logic [31:0] valE,
                              input logic [31:0] valA, input logic [4:0] dstE,
                              input logic [4:0] dstM, input logic bub,
                              input logic [31:0] expValM, input logic expErr,
                              input logic expBusy);
    vec_t v;
    v.d = d; v.op = op; v.valE = valE; v.valA = valA; v.dstE = dstE; v.dstM = dstM;
    v.bub = bub; v.expValM = expValM; v.expErr = expErr; v.expBusy = expBusy;
    return v;
  endfunction

  // Present one op, expect busy for the configured latency, then pop and compare the W capture
  task automatic runOp(input vec_t v, input string tag);
    wRec_t e;
    wRec_t zero;
    int d;
    d = v.d;
    zero = '0;
    if (v.bub) e = '0;
    else e = '{op: v.op, valE: v.valE, valM: v.expValM, dstE: v.dstE, dstM: v.dstM,
               err: v.expErr};
    sbq.push_back(e);
    mOp[d] = v.op; mValE[d] = v.valE; mValA[d] = v.valA; mDstE[d] = v.dstE; mDstM[d] = v.dstM;
    #1;
    if (v.expBusy) begin
      for (int i = 0; i < int'(lat[d]); i++) begin
        check({tag, ".busy"}, 32'(busy[d]), 32'd1);
        tick();
        checkW(d, {tag, ".nop"}, zero);
      end
    end
    check({tag, ".done"}, 32'(busy[d]), 32'd0);
    wBub[d] = v.bub;
    tick();
    wBub[d] = 1'b0;
    checkW(d, tag, sbq.pop_front());
    driveNop(d);
  endtask

  initial begin
    wRec_t zero;
    wRec_t hold;
    vec_t v;
    zero = '0;
    nChecks = 0;
    nErrors = 0;
    lat[0] = 2;
    lat[1] = 0;
    for (int d = 0; d < 2; d++) begin
      driveNop(d);
      wStall[d] = 1'b0;
      wBub[d] = 1'b0;
    end
    rst = 1'b1;
    #1;
    checkW(0, "reset0", zero);
    checkW(1, "reset1", zero);
    check("reset0.busy", 32'(busy[0]), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // d, op, valE, valA, dstE, dstM, bubble, expValM, expErr, expBusy
    vecs.push_back(mk(0, ISW,   32'h8,    32'h12345678, 5'd0, 5'd0, 0, 32'h0,        0, 1));
    vecs.push_back(mk(0, ILW,   32'h8,    32'h0,        5'd0, 5'd5, 0, 32'h12345678, 0, 1));
    vecs.push_back(mk(0, IADDI, 32'h3,    32'h0,        5'd3, 5'd0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(0, ILW,   32'h6,    32'h0,        5'd0, 5'd6, 0, 32'h0,        1, 0));
    vecs.push_back(mk(0, ILW,   32'h8,    32'h0,        5'd0, 5'd6, 0, 32'h12345678, 0, 1));
    vecs.push_back(mk(0, ISW,   32'h0,    32'h11,       5'd0, 5'd0, 0, 32'h0,        0, 1));
    vecs.push_back(mk(0, ISW,   32'h2,    32'hFFFF,     5'd0, 5'd0, 0, 32'h0,        1, 0));
    vecs.push_back(mk(0, ILW,   32'h0,    32'h0,        5'd0, 5'd8, 0, 32'h11,       0, 1));
    vecs.push_back(mk(0, ISW,   32'h1004, 32'hA5A5,     5'd0, 5'd0, 0, 32'h0,        0, 1));
    vecs.push_back(mk(0, ILW,   32'h4,    32'h0,        5'd0, 5'd2, 0, 32'hA5A5,     0, 1));
    vecs.push_back(mk(0, IROP,  32'hCAFE, 32'h0,        5'd7, 5'd9, 0, 32'h0,        0, 0));
    vecs.push_back(mk(1, ISW,   32'h4,    32'h55,       5'd0, 5'd0, 0, 32'h0,        0, 1));
    vecs.push_back(mk(1, IADDI, 32'h3,    32'h0,        5'd3, 5'd0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(1, ILW,   32'h4,    32'h0,        5'd0, 5'd1, 0, 32'h55,       0, 1));
    vecs.push_back(mk(1, ISW,   32'h40,   32'h9,        5'd0, 5'd0, 1, 32'h0,        0, 1));
    vecs.push_back(mk(1, ILW,   32'h0,    32'h0,        5'd0, 5'd4, 0, 32'h9,        0, 1));
    vecs.push_back(mk(1, ILW,   32'h6,    32'h0,        5'd0, 5'd4, 0, 32'h0,        1, 0));
    vecs.push_back(mk(1, IORI,  32'h5,    32'h0,        5'd2, 5'd0, 0, 32'h0,        0, 0));
    foreach (vecs[i]) runOp(vecs[i], $sformatf("vec%0d", i));

    // Stall while an op waits in IDLE: W holds the previous capture, FSM frozen
    runOp(mk(0, IROP, 32'hBEEF, 32'h0, 5'd4, 5'd0, 0, 32'h0, 0, 0), "preStall");
    hold = '{op: IROP, valE: 32'hBEEF, valM: 32'h0, dstE: 5'd4, dstM: 5'd0, err: 1'b0};
    mOp[0] = ISW; mValE[0] = 32'hC; mValA[0] = 32'h7;
    wStall[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkW(0, "stallIdle", hold);
      check("stallIdle.busy", 32'(busy[0]), 32'd1);
    end
    wStall[0] = 1'b0;
    tick();
    checkW(0, "stallCnt1", zero);
    check("stallCnt1.busy", 32'(busy[0]), 32'd1);
    tick();
    check("stallCnt0.busy", 32'(busy[0]), 32'd0);
    // Stall for three cycles with the counter at zero
    wStall[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkW(0, "stallDone", zero);
      check("stallDone.busy", 32'(busy[0]), 32'd0);
    end
    wStall[0] = 1'b0;
    tick();
    checkW(0, "stallRel", '{op: ISW, valE: 32'hC, valM: 32'h0, dstE: 5'd0, dstM: 5'd0,
                            err: 1'b0});
    driveNop(0);
    runOp(mk(0, ILW, 32'hC, 32'h0, 5'd0, 5'd3, 0, 32'h7, 0, 1), "stallLoad");

    // Reset in the second cycle of a store drops the write
    mOp[0] = ISW; mValE[0] = 32'h10; mValA[0] = 32'hDEADBEEF;
    #1;
    check("rstMid.busy0", 32'(busy[0]), 32'd1);
    tick();
    rst = 1'b1;
    driveNop(0);
    #1;
    checkW(0, "rstMid", zero);
    check("rstMid.busy", 32'(busy[0]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    checkW(0, "rstPost", zero);
    mOp[0] = ILW; mValE[0] = 32'h10; mDstM[0] = 5'd1;
    for (int i = 0; i < int'(lat[0]) + 1; i++) tick();
    nChecks++;
    if (wValM[0] === 32'hDEADBEEF || wOp[0] !== ILW) begin
      nErrors++;
      $display("FAIL rstDrop: W_op=0x%0h W_valM=0x%08h, expected ILW with data != 0xDEADBEEF",
               wOp[0], wValM[0]);
    end
    driveNop(0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipelined MIPS CPU, sitting between the M pipeline register and the register-file write-back.
- Consumes the M-register outputs (M_op, M_valE, M_valA, M_dstE, M_dstM).
- Performs data-memory loads and stores with a configurable access latency, and drives the stall request to the hazard unit.
- Owns the W pipeline register, with stall and bubble control.

Parameters:
- ADDR_W, 10, word-address width; data memory holds 2^ADDR_W 32-bit words.
- MEM_LAT, 2, extra wait cycles per load/store (0 = single-cycle access).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- M_op  in  6  opcode from M register
- M_valE  in  32  ALU result; byte address for ILW/ISW
- M_valA  in  32  store data
- M_dstE  in  5  ALU destination register
- M_dstM  in  5  load destination register
- W_stall  in  1  hold W register and freeze access FSM
- W_bubble  in  1  load NOP into W register
- m_busy  out  1  combinational stall request to hazard unit
- W_op  out  6  registered opcode
- W_valE  out  32  registered ALU result
- W_valM  out  32  registered load data
- W_dstE  out  5  registered ALU destination
- W_dstM  out  5  registered load destination
- W_err  out  1  registered misaligned-access flag

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE, counter to 0.
  - W_op, W_valE, W_valM, W_dstE, W_dstM and W_err all 0.
  - Any pending store is dropped and never written.
  - Memory contents are not reset.
- mem_op = (M_op==`ILW || M_op==`ISW). misal = mem_op && M_valE[1:0]!=0.
- Word index = M_valE[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^ADDR_W words.
- FSM states: IDLE, ACCESS; counter cnt is wide enough for MEM_LAT.
  - IDLE, mem_op, !misal, MEM_LAT>0: m_busy=1. Next state ACCESS, cnt=MEM_LAT-1.
  - ACCESS: m_busy = (cnt!=0).
    - If cnt!=0 and !W_stall: cnt decrements.
    - If cnt==0 and !W_stall: access completes, next state IDLE.
  - MEM_LAT=0, or misal, or non-memory op: completes in the presentation cycle with m_busy=0.
- Total cycles from op presentation to W capture: MEM_LAT+1.
- Environment rule: the hazard unit holds the M-register inputs stable while m_busy=1. The block does not re-sample them mid-access.
- W_stall=1 freezes the FSM and counter. m_busy stays as computed in the frozen state.
- Store: memory write occurs exactly once, on the completing edge, and only if !W_stall and !misal. W_valM=0.
- Load: combinational read at the completing edge; W_valM = mem[index].
- A load on the edge immediately following a store to the same word returns the new data.
- Non-memory ops: no memory access; W_valM=0.
- W register update priority: rst > W_stall > W_bubble > m_busy > normal.
  - W_stall: all W outputs hold.
  - W_bubble: W_op=0 (NOP), all other W outputs 0. A store completing on this edge still writes memory.
  - m_busy=1 (and no stall or bubble): W loads a NOP bubble (all zeros).
  - Normal: W_op=M_op, W_valE=M_valE, W_dstE=M_dstE, W_dstM=M_dstM, W_valM per the load/store/non-memory rules above, W_err=misal.
- Misaligned ILW/ISW: no memory read or write. W_valM=0 and W_err=1 for exactly the one captured instruction, with no wait cycles.

Decomposition:
- Shared defines header (already shared by the pipeline registers) holds opcodes `ILW, `ISW, `IROP, `IADDI, `IANDI, `IORI, `IJ and `NOP=6'b0. Add the FSM state encodings there.
- One natural sub-module, data_mem: 2^ADDR_W x 32, synchronous write, asynchronous read, ports clk/we/addr/wdata/rdata.
- The FSM and W register stay in mem_stage.

Test Plan:
- Reset mid-access: MEM_LAT=2, ISW addr 0x10 data 0xDEADBEEF; assert rst in 2nd cycle. -> All W outputs 0, m_busy=0; a later ILW at 0x10 does not return 0xDEADBEEF (mem preloaded 0).
- Store/load, MEM_LAT=2: ISW addr 0x8 data 0x12345678, then ILW addr 0x8 dstM=5. -> m_busy high 2 cycles per op, W gets NOPs during busy. Load's W_valM=0x12345678, W_dstM=5, captured on the 3rd edge.
- MEM_LAT=0 back-to-back: IADDI valE=3 dstE=3, then ILW addr 0x4. -> m_busy never asserts, one W capture per cycle, W_valE=3 then W_valM=mem[1].
- Misaligned: ILW addr 0x6. -> no busy, W_err=1 for one cycle, W_valM=0; next aligned op has W_err=0.
- W_stall during ACCESS (MEM_LAT=2, ISW 0xC data 7, stall 3 cycles at cnt==0). -> W holds, exactly one write, mem[3]=7 after stall release.
- Wrap: ADDR_W=4, ISW addr 0x40 data 9. -> mem[0]=9; W_bubble on completing edge gives W_op=0 but write still occurs.
